booth_seq_multiplier: RTL and testbench

BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

---
 rtl/booth_seq_multiplier_pkg.sv | 22 ++
 rtl/booth_r4_recoder.sv | 23 ++
 rtl/booth_seq_multiplier.sv | 116 +++++++++++
 tb/tb_booth_seq_multiplier.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_seq_multiplier_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
// Latency: none (types only).
// Backpressure: none (types only).
// Contents: FSM state encoding and Booth digit select encoding.
package booth_seq_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Digit selected by one radix-4 Booth recoding step.
  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_POS1 = 3'd1,
    SEL_POS2 = 3'd2,
    SEL_NEG1 = 3'd3,
    SEL_NEG2 = 3'd4
  } booth_sel_t;

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: three overlapping multiplier bits -> digit select.
// Latency: purely combinational.
// Backpressure: none.
// Ports: bits[2:0] = {b[2i+1], b[2i], b[2i-1]}; sel = 0 / +-1 / +-2 multiple of A.
module booth_r4_recoder
  import booth_seq_multiplier_pkg::*;
(
  input  logic [2:0] bits,
  output booth_sel_t sel
);

  always_comb begin
    sel = SEL_ZERO;
    case (bits)
      3'b001, 3'b010: sel = SEL_POS1;
      3'b011:         sel = SEL_POS2;
      3'b100:         sel = SEL_NEG2;
      3'b101, 3'b110: sel = SEL_NEG1;
      default:        sel = SEL_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, one recoded digit per clock, signed or unsigned.
// Latency: done pulses WIDTH/2+1 clocks after start is sampled; hi/lo load on that edge.
// Backpressure: start is ignored while busy; a new start may be accepted in the DONE cycle.
// Ports: clock, clear (async, active-high), start, mode_signed, multiplicand, multiplier
//        -> busy (iterating), done (1-cycle pulse), hi/lo (product halves, held between results).
module booth_seq_multiplier
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             mode_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);
  // Upper (adding) part of the accumulator: WIDTH+2 operand bits, one bit for 2A,
  // one guard bit so the running partial sum never overflows.
  localparam int UW   = WIDTH + 4;
  // Full accumulator: upper part plus the WIDTH+2 product bits shifted out below it.
  localparam int AW   = UW + WIDTH + 2;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH+1:0] a_ext;
  // Multiplier shift register with an implicit 0 below bit 0 for the first digit.
  logic [WIDTH+2:0] mreg;
  logic [AW-1:0]   acc;

  booth_sel_t      sel;
  logic [UW-1:0]   a_sx;
  logic [UW-1:0]   addend;
  logic [UW-1:0]   upper_sum;
  logic [AW-1:0]   pre_shift;
  logic [AW-1:0]   acc_next;

  function automatic logic [WIDTH+1:0] extend(input logic [WIDTH-1:0] x, input logic sgn);
    return sgn ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  endfunction

  booth_r4_recoder u_recoder (
    .bits (mreg[2:0]),
    .sel  (sel)
  );

  always_comb begin
    a_sx   = {{2{a_ext[WIDTH+1]}}, a_ext};
    addend = '0;
    case (sel)
      SEL_POS1: addend = a_sx;
      SEL_POS2: addend = a_sx << 1;
      SEL_NEG1: addend = -a_sx;
      SEL_NEG2: addend = -(a_sx << 1);
      default:  addend = '0;
    endcase
    upper_sum = acc[AW-1:WIDTH+2] + addend;
    pre_shift = {upper_sum, acc[WIDTH+1:0]};
    acc_next  = $signed(pre_shift) >>> 2;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      a_ext <= '0;
      mreg  <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_ext <= extend(multiplicand, mode_signed);
            mreg  <= {extend(multiplier, mode_signed), 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= ST_CALC;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_CALC: begin
          acc  <= acc_next;
          mreg <= mreg >> 2;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            {hi, lo}  <= acc_next[2*WIDTH-1:0];
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier (WIDTH=32).
// Latency: expects done exactly 17 clocks after start is sampled.
// Backpressure: exercises ignored starts during CALC and restart in the DONE cycle.
module tb_booth_seq_multiplier;

  localparam int W    = 32;
  localparam int ITER = W / 2 + 1;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic         mode_signed;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clock        (clock),
    .clear        (clear),
    .start        (start),
    .mode_signed  (mode_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sgn);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return 64'(ua * ub);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; start is sampled at the next rising edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    multiplicand = a;
    multiplier   = b;
    mode_signed  = sgn;
    start        = 1'b1;
    @(negedge clock);
    start        = 1'b0;
  endtask

  // Counts falling edges until done, noting whether hi/lo moved meanwhile.
  task automatic wait_done(output int lat, output bit held);
    logic [W-1:0] h0, l0;
    h0   = hi;
    l0   = lo;
    lat  = 0;
    held = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input string tag);
    logic [63:0] exp;
    int          lat;
    bit          held;
    exp = ref_mul(a, b, sgn);
    launch(a, b, sgn);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat, held);
    check({tag, "_lat"}, 64'(lat), 64'(ITER));
    check({tag, "_prod"}, {hi, lo}, exp);
    check({tag, "_hold"}, 64'(held), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int  lat;
    bit  held;
    int  n_done;
    int  gap;
    logic [W-1:0] h0, l0;
    logic [W-1:0] ra, rb;
    logic         rs;

    clear        = 1'b1;
    start        = 1'b0;
    mode_signed  = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    #20;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    // Reference example and corner operands.
    do_mul(32'h0007_8945, 32'h0005_4987, 1'b1, "example");
    check("example_hi", 64'(hi), 64'h27);
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, "s_minmin");
    do_mul(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, "s_neg2x3");
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_maxmax");
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "s_m1m1");
    @(negedge clock);
    check("pulse_one_cycle", 64'(done), 64'd0);

    // Start re-asserted and operands changed mid-CALC must be ignored.
    h0 = hi;
    l0 = lo;
    launch(32'd5, 32'd7, 1'b0);
    @(negedge clock);
    @(negedge clock);
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(negedge clock);
    check("ign_busy", 64'(busy), 64'd1);
    check("ign_hold_early", {hi, lo}, {h0, l0});
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    wait_done(lat, held);
    check("ign_lat", 64'(lat), 64'(ITER - 3));
    check("ign_prod", {hi, lo}, 64'h23);
    check("ign_hold", 64'(held), 64'd1);
    n_done = 0;
    repeat (30) begin
      @(negedge clock);
      if (done === 1'b1) n_done++;
    end
    check("ign_single_done", 64'(n_done), 64'd0);

    // Back-to-back: second start lands in the DONE cycle of the first.
    do_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "b2b_first");
    do_mul(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, "b2b_second");

    // Clear in the middle of an operation.
    @(negedge clock);
    launch(32'hCAFE_F00D, 32'h0000_1234, 1'b0);
    repeat (7) @(negedge clock);
    #1 clear = 1'b1;
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_hi",   64'(hi),   64'd0);
    check("clr_lo",   64'(lo),   64'd0);
    @(negedge clock);
    clear  = 1'b0;
    n_done = 0;
    repeat (30) begin
      @(negedge clock);
      if (done === 1'b1) n_done++;
    end
    check("clr_no_done", 64'(n_done), 64'd0);
    do_mul(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "after_clr");

    // Randomized operands, modes and idle gaps.
    for (int i = 0; i < 24; i++) begin
      ra  = pick_operand();
      rb  = pick_operand();
      rs  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        @(negedge clock);
        check($sformatf("rnd%0d_done_low", i), 64'(done), 64'd0);
        repeat (gap - 1) @(negedge clock);
      end
      do_mul(ra, rb, rs, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
